// File: rtl/data_memory_sized.sv
// data_memory_sized: dual-port byte/half/word data memory that zero-fills itself after reset.
module data_memory_sized #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [1:0]            read_size,
  input  logic                  read_unsigned,
  output logic [DW-1:0]         read_data,
  output logic                  read_valid,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [1:0]            write_size,
  input  logic [DW-1:0]         write_data,
  output logic                  busy,
  output logic                  error
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [IW-1:0] clear_ptr, ridx, widx;
  logic [DW-1:0] mem [DEPTH];
  logic ready, rd_ok, rd_bad, wr_ok, wr_bad;
  logic [3:0] be;
  logic [DW-1:0] wd, rword, rsel;
  logic [7:0] rb;
  logic [15:0] rh;
  // Legal: defined size, naturally aligned, and no address bit above the word index set.
  function automatic logic legal(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] s);
    return s != 2'b11 && !(s == 2'b01 && a[0]) && !(s == 2'b10 && a[1:0] != 2'b00)
      && (a >> (IW + 2)) == '0;
  endfunction
  always_comb begin
    ready = rst_n && state == READY;
    rd_ok = ready && mem_read && legal(read_addr, read_size);
    rd_bad = ready && mem_read && !legal(read_addr, read_size);
    wr_ok = ready && mem_write && legal(write_addr, write_size);
    wr_bad = ready && mem_write && !legal(write_addr, write_size);
    ridx = read_addr[IW+1:2];
    widx = write_addr[IW+1:2];
    be = write_size == 2'b00 ? 4'b0001 << write_addr[1:0] :
         write_size == 2'b01 ? (write_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = write_size == 2'b00 ? {4{write_data[7:0]}} :
         write_size == 2'b01 ? {2{write_data[15:0]}} : write_data;
    rword = mem[ridx];
    rb = rword[8*read_addr[1:0] +: 8];
    rh = read_addr[1] ? rword[31:16] : rword[15:0];
    rsel = read_size == 2'b00 ? {{24{~read_unsigned & rb[7]}}, rb} :
           read_size == 2'b01 ? {{16{~read_unsigned & rh[15]}}, rh} : rword;
  end
  assign busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      clear_ptr <= '0;
      read_data <= '0;
      read_valid <= 1'b0;
      error <= 1'b0;
    end else begin
      read_valid <= rd_ok;
      error <= rd_bad | wr_bad;
      if (rd_ok) read_data <= rsel;
      if (state == CLEAR) begin
        clear_ptr <= clear_ptr + IW'(1);
        if (clear_ptr == IW'(DEPTH - 1)) state <= READY;
      end
    end
  end
  // Array has no reset; the clear sequencer zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (rst_n && state == CLEAR) mem[clear_ptr] <= '0;
    else if (wr_ok)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: directed self-checking bench for data_memory_sized (DEPTH=32).
module tb_data_memory_sized;
  logic clk = 1'b0;
  logic rst_n, mem_read, read_unsigned, mem_write, read_valid, busy, error;
  logic [31:0] read_addr, write_addr, write_data, read_data;
  logic [1:0] read_size, write_size;
  int tests = 0, fails = 0, n;
  always #5 clk = ~clk;
  data_memory_sized dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .read_addr(read_addr), .read_size(read_size),
    .read_unsigned(read_unsigned), .read_data(read_data), .read_valid(read_valid),
    .mem_write(mem_write), .write_addr(write_addr), .write_size(write_size),
    .write_data(write_data), .busy(busy), .error(error)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask
  task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    mem_write = 1'b1; write_addr = a; write_size = s; write_data = d;
    tick();
    mem_write = 1'b0;
    check("store_err", error, 0);
  endtask
  task automatic load(input string tag, input logic [31:0] a, input logic [1:0] s,
                      input logic u, input logic [31:0] exp);
    mem_read = 1'b1; read_addr = a; read_size = s; read_unsigned = u;
    tick();
    mem_read = 1'b0;
    check({tag, "_valid"}, read_valid, 1);
    check(tag, read_data, exp);
  endtask
  task automatic illegal(input string tag, input logic [31:0] hold);
    tick();
    idle();
    check({tag, "_err"}, error, 1);
    check({tag, "_rv"}, read_valid, 0);
    check({tag, "_hold"}, read_data, hold);
    tick();
    check({tag, "_err_end"}, error, 0);
  endtask
  task automatic wait_ready(input string tag, input int exp);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask
  initial begin
    rst_n = 1'b0; idle();
    read_addr = '0; read_size = '0; read_unsigned = 1'b0;
    write_addr = '0; write_size = '0; write_data = '0;
    tick(); tick();
    check("rst_busy", busy, 1);
    check("rst_rv", read_valid, 0);
    check("rst_err", error, 0);
    check("rst_rd", read_data, 0);
    rst_n = 1'b1;
    wait_ready("busy_len_init", 32);
    store(32'h14, 2'b10, 32'hDEADBEEF);
    load("lw_pre", 32'h14, 2'b10, 1'b0, 32'hDEADBEEF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_rd2", read_data, 0);
    wait_ready("busy_len_reset", 32);
    load("lw_cleared", 32'h14, 2'b10, 1'b0, 32'h0);
    tick();
    check("rv_pulse_end", read_valid, 0);
    store(32'h10, 2'b10, 32'h11223344);
    store(32'h11, 2'b00, 32'h000000F0);
    load("lw_10", 32'h10, 2'b10, 1'b0, 32'h1122F044);
    load("lb_11", 32'h11, 2'b00, 1'b0, 32'hFFFFFFF0);
    load("lbu_11", 32'h11, 2'b00, 1'b1, 32'h000000F0);
    load("lh_12", 32'h12, 2'b01, 1'b0, 32'h00001122);
    store(32'h20, 2'b01, 32'h00008001);
    load("lh_20", 32'h20, 2'b01, 1'b0, 32'hFFFF8001);
    load("lhu_20", 32'h20, 2'b01, 1'b1, 32'h00008001);
    store(32'h04, 2'b10, 32'h5A5A5A5A);
    load("lw_w1_before", 32'h04, 2'b10, 1'b0, 32'h5A5A5A5A);
    mem_read = 1'b1; read_addr = 32'h02; read_size = 2'b10;
    illegal("lw_misal", 32'h5A5A5A5A);
    mem_write = 1'b1; write_addr = 32'h07; write_size = 2'b01; write_data = 32'h0000FFFF;
    illegal("sh_misal", 32'h5A5A5A5A);
    mem_read = 1'b1; read_addr = 32'h80; read_size = 2'b10;
    illegal("lw_range", 32'h5A5A5A5A);
    mem_write = 1'b1; write_addr = 32'h84; write_size = 2'b10; write_data = 32'h0;
    illegal("sw_range", 32'h5A5A5A5A);
    mem_read = 1'b1; read_addr = 32'h04; read_size = 2'b11;
    illegal("rsize_res", 32'h5A5A5A5A);
    mem_write = 1'b1; write_addr = 32'h04; write_size = 2'b11; write_data = 32'h0;
    illegal("wsize_res", 32'h5A5A5A5A);
    mem_read = 1'b1; read_addr = 32'h80; read_size = 2'b10;
    mem_write = 1'b1; write_addr = 32'h06; write_size = 2'b10; write_data = 32'h0;
    illegal("both_bad", 32'h5A5A5A5A);
    load("lw_w1_after", 32'h04, 2'b10, 1'b0, 32'h5A5A5A5A);
    store(32'h08, 2'b10, 32'hAAAA0000);
    mem_write = 1'b1; write_addr = 32'h08; write_size = 2'b10; write_data = 32'h12345678;
    mem_read = 1'b1; read_addr = 32'h08; read_size = 2'b10;
    tick();
    idle();
    check("same_rv", read_valid, 1);
    check("same_rd", read_data, 32'hAAAA0000);
    check("same_err", error, 0);
    load("lw_after_same", 32'h08, 2'b10, 1'b0, 32'h12345678);
    mem_read = 1'b1; read_addr = 32'h10; read_size = 2'b10;
    tick();
    check("b2b_rv0", read_valid, 1);
    check("b2b_rd0", read_data, 32'h1122F044);
    read_addr = 32'h20;
    tick();
    idle();
    check("b2b_rv1", read_valid, 1);
    check("b2b_rd1", read_data, 32'h00008001);
    tick();
    check("b2b_rv_end", read_valid, 0);
    check("b2b_hold", read_data, 32'h00008001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    store(32'h00, 2'b10, 32'h1);
    check("busy_mid", busy, 1);
    mem_read = 1'b1; read_addr = 32'h10; read_size = 2'b10;
    tick();
    idle();
    check("busy_rv", read_valid, 0);
    check("busy_err", error, 0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    store(32'h00, 2'b10, 32'h1);
    wait_ready("busy_len_mid", 26);
    load("lw_busy_ignored", 32'h00, 2'b10, 1'b0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the processor's single-port word data memory.
- Separate read and write ports, both usable in the same cycle.
- Supports byte, halfword and word accesses, with sign/zero extension on loads and byte-lane writes.
- Detects misaligned, out-of-range and reserved-size accesses; zero-fills itself after reset using an internal clear sequencer.
- Sits between the MEM pipeline stage and the MEM/WB register.

Parameters:
ADDR_WIDTH, 32, width of byte addresses on both ports
DEPTH, 32, number of 32-bit words; power of two, >= 2
DW, 32, data width; fixed at 32 (4 byte lanes), not overridable in practice

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
mem_read  input  1  read request this cycle
read_addr  input  ADDR_WIDTH  byte address of load
read_size  input  2  00 byte, 01 half, 10 word, 11 reserved
read_unsigned  input  1  1 = zero-extend sub-word load, 0 = sign-extend
read_data  output  32  registered load result
read_valid  output  1  one-cycle pulse; read_data holds a fresh legal result
mem_write  input  1  write request this cycle
write_addr  input  ADDR_WIDTH  byte address of store
write_size  input  2  same encoding as read_size
write_data  input  32  store data; sub-word stores use the low bits
busy  output  1  high while the clear sequence runs; requests ignored
error  output  1  one-cycle pulse for an illegal request

Behaviour:
- Reset: rst_n=0 at a posedge forces state CLEAR, clear_ptr=0, read_data=0, read_valid=0, error=0, busy=1.
- Reset asserted mid-CLEAR or mid-READY restarts the clear sequence from word 0.
- FSM has 2 states:
  - CLEAR: each cycle writes word[clear_ptr]=0 and increments clear_ptr. After writing word DEPTH-1, moves to READY.
  - READY: busy=0; normal operation.
- busy is 1 for exactly DEPTH cycles after the first posedge with rst_n=1.
- While busy, mem_read and mem_write are ignored: no memory change, no read_valid, no error.
- Word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0]. Little-endian: byte lane 0 is bits 7:0.
- A request is illegal if any of the following holds:
  - size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=00;
  - any addr bit above log2(DEPTH)+1 is set (out of range).
- Illegal requests never modify memory and never raise read_valid. error=1 in the next cycle, for one cycle. If both ports are illegal in the same cycle, error is still a single pulse.
- Store (READY, mem_write, legal), committed at the posedge:
  - byte: write_data[7:0] into lane addr[1:0];
  - half: write_data[15:0] into lanes {addr[1],1} and {addr[1],0};
  - word: all 32 bits.
  - Other lanes are unchanged.
- Load (READY, mem_read, legal): 1-cycle latency.
  - At the posedge, read_data is loaded with the selected byte/half/word, extended per read_unsigned (word loads ignore it), and read_valid=1 for that following cycle only.
  - When no legal read occurs, read_data holds its last value and read_valid=0.
- Same cycle, legal read and write to the same word: read-before-write. The load returns pre-store contents; the store commits in the same edge.
- Back-to-back loads every cycle yield read_valid high continuously, with 1-cycle latency each.

Test Plan:
- Reset clear: pre-load word 5 with 32'hDEADBEEF, pulse rst_n low 1 cycle -> busy high exactly 32 cycles; afterwards a word load of addr 0x14 -> read_data=0, read_valid pulse 1 cycle later.
- Sub-word stores and loads: SW 0x10 <= 32'h11223344; SB 0x11 <= 8'hF0; LW 0x10 -> 32'h1122F044; LB 0x11 signed -> 32'hFFFFFFF0; LBU 0x11 -> 32'h000000F0; LH 0x12 signed -> 32'h00001122.
- Halfword sign extension: SH 0x20 <= 16'h8001 -> LH 0x20 = 32'hFFFF8001, LHU 0x20 = 32'h00008001.
- Illegal requests: LW 0x02, SH 0x07, access to 0x80 with DEPTH=32, size=11 -> each gives a single error pulse, no read_valid, memory unchanged (verify with LW 0x04 before/after).
- Simultaneous same-word access: word 0x08 = 32'hAAAA0000; same cycle SW 0x08 <= 32'h12345678 and LW 0x08 -> read_data=32'hAAAA0000; next LW 0x08 -> 32'h12345678.
- Busy and mid-clear reset: issue SW 0x00 <= 1 at clear cycle 3 -> ignored, no error. Assert rst_n low at clear cycle 10 -> busy persists 32 more cycles from restart; LW 0x00 afterwards -> 0.
